// File: rtl/load_extend_unit.sv
// rtl/load_extend_unit.sv - load alignment/extension stage with 2-entry elastic output buffer
module load_extend_unit #(
  parameter int DATA_W = 32,
  parameter int AW     = $clog2(DATA_W / 8),
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_addr,
  input  logic [1:0]        in_size,
  input  logic              in_uns,
  input  logic [DATA_W-1:0] in_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic                main_err_q, main_err_d, skid_err_q, skid_err_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;

  logic [DATA_W-1:0]   sh, mask, res_data;
  logic [63:0]         mask64;
  logic [2:0]          addr3;
  logic                sign, res_err, accept, drain;

  // Field mask is built at 64 bits and truncated so one path serves both widths.
  always_comb begin
    sh      = in_rdata >> {in_addr, 3'b000};
    addr3   = 3'(in_addr);
    mask64  = '1;
    sign    = sh[DATA_W-1];
    res_err = 1'b0;
    case (in_size)
      2'd0: begin
        mask64 = 64'h0000_0000_0000_00FF;
        sign   = sh[7];
      end
      2'd1: begin
        mask64  = 64'h0000_0000_0000_FFFF;
        sign    = sh[15];
        res_err = addr3[0];
      end
      2'd2: begin
        mask64  = 64'h0000_0000_FFFF_FFFF;
        sign    = sh[31];
        res_err = (addr3[1:0] != 2'b00);
      end
      default: begin
        res_err = (DATA_W == 32) || (addr3 != 3'b000);
      end
    endcase
    mask     = mask64[DATA_W-1:0];
    res_data = (sh & mask) | ((sign & ~in_uns) ? ~mask : '0);
    if (res_err) res_data = '0;
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_data_q;
  assign out_err   = main_err_q;
  assign err_cnt   = err_cnt_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    err_cnt_d   = err_cnt_q;
    if (accept && res_err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = ONE;
          main_data_d = res_data;
          main_err_d  = res_err;
        end
      end
      ONE: begin
        if (accept && drain) begin
          main_data_d = res_data;
          main_err_d  = res_err;
        end else if (accept) begin
          state_d     = FULL;
          skid_data_d = res_data;
          skid_err_d  = res_err;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // in_ready is low here, so only the skid-to-main move can happen.
        if (drain) begin
          state_d     = ONE;
          main_data_d = skid_data_q;
          main_err_d  = skid_err_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_load_extend_unit.sv
// tb/tb_load_extend_unit.sv - scoreboard bench for load_extend_unit (32-bit and 64-bit instances)
module tb_load_extend_unit;

  typedef struct {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_ready = 1'b1;

  logic        iv32 = 1'b0, ir32, uns32 = 1'b0, ov32, oe32;
  logic [1:0]  a32 = '0, sz32 = '0;
  logic [31:0] rd32 = '0, od32;
  logic [15:0] ec32;

  logic        iv64 = 1'b0, ir64, uns64 = 1'b0, ov64, oe64;
  logic [2:0]  a64 = '0;
  logic [1:0]  sz64 = '0;
  logic [63:0] rd64 = '0, od64;
  logic [1:0]  ec64;

  exp_t q32[$];
  exp_t q64[$];
  int   tests = 0;
  int   fails = 0;
  bit   c_done = 1'b0;

  always #5 clk = ~clk;

  load_extend_unit #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_addr(a32),
    .in_size(sz32), .in_uns(uns32), .in_rdata(rd32), .out_valid(ov32),
    .out_ready(out_ready), .out_data(od32), .out_err(oe32), .err_cnt(ec32));

  load_extend_unit #(.DATA_W(64), .CNT_W(2)) dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_addr(a64),
    .in_size(sz64), .in_uns(uns64), .in_rdata(rd64), .out_valid(ov64),
    .out_ready(out_ready), .out_data(od64), .out_err(oe64), .err_cnt(ec64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input bit w64, input logic [63:0] rd, input logic [2:0] addr,
                      input logic [1:0] size, input logic uns,
                      input logic [63:0] exp_d, input logic exp_e);
    exp_t e;
    bit   ok = 1'b0;
    e.data = exp_d;
    e.err  = exp_e;
    if (w64) begin
      iv64 = 1'b1; rd64 = rd; a64 = addr; sz64 = size; uns64 = uns;
    end else begin
      iv32 = 1'b1; rd32 = rd[31:0]; a32 = addr[1:0]; sz32 = size; uns32 = uns;
    end
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (w64 ? ir64 : ir32) begin
        if (w64) q64.push_back(e); else q32.push_back(e);
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    if (w64) iv64 = 1'b0; else iv32 = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ov32 && out_ready) begin
      if (q32.size() == 0) chk("unexpected_out32", 64'd1, 64'd0);
      else begin
        e = q32.pop_front();
        chk("out32_data", {32'd0, od32}, e.data);
        chk("out32_err", {63'd0, oe32}, {63'd0, e.err});
      end
    end
    if (ov64 && out_ready) begin
      if (q64.size() == 0) chk("unexpected_out64", 64'd1, 64'd0);
      else begin
        e = q64.pop_front();
        chk("out64_data", od64, e.data);
        chk("out64_err", {63'd0, oe64}, {63'd0, e.err});
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {63'd0, ov32}, 64'd0);
    chk("rst_out_data", {32'd0, od32}, 64'd0);
    chk("rst_err_cnt", {48'd0, ec32}, 64'd0);
    chk("rst_in_ready", {63'd0, ir32}, 64'd1);
    rst = 1'b0;

    // Byte/half/word extraction with sign and zero extension
    send(0, 64'h12345680, 3'd0, 2'd0, 1'b0, 64'hFFFFFF80, 1'b0);
    chk("latency_1cyc", {63'd0, ov32}, 64'd1);
    send(0, 64'h12345680, 3'd0, 2'd0, 1'b1, 64'h00000080, 1'b0);
    send(0, 64'h12345680, 3'd1, 2'd0, 1'b0, 64'h00000056, 1'b0);
    send(0, 64'h80011234, 3'd2, 2'd1, 1'b0, 64'hFFFF8001, 1'b0);
    send(0, 64'h80011234, 3'd3, 2'd0, 1'b1, 64'h00000080, 1'b0);
    send(0, 64'h80011234, 3'd0, 2'd1, 1'b0, 64'h00001234, 1'b0);
    send(0, 64'h80011234, 3'd0, 2'd2, 1'b0, 64'h80011234, 1'b0);

    // Misaligned and illegal accesses
    send(0, 64'hDEADBEEF, 3'd1, 2'd2, 1'b0, 64'd0, 1'b1);
    chk("err_cnt_1", {48'd0, ec32}, 64'd1);
    send(0, 64'hDEADBEEF, 3'd0, 2'd3, 1'b0, 64'd0, 1'b1);
    chk("err_cnt_2", {48'd0, ec32}, 64'd2);
    send(0, 64'hDEADBEEF, 3'd1, 2'd1, 1'b1, 64'd0, 1'b1);
    chk("err_cnt_3", {48'd0, ec32}, 64'd3);

    // 64-bit datapath and counter saturation (2-bit counter saturates at 3)
    send(1, 64'h8000_0000_0000_0000, 3'd4, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send(1, 64'h8000_0000_0000_0000, 3'd4, 2'd2, 1'b1, 64'h0000_0000_8000_0000, 1'b0);
    send(1, 64'h8000_0000_0000_0000, 3'd0, 2'd3, 1'b0, 64'h8000_0000_0000_0000, 1'b0);
    send(1, 64'h8000_0000_0000_0000, 3'd7, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    send(1, 64'h0123_4567_89AB_CDEF, 3'd4, 2'd3, 1'b0, 64'd0, 1'b1);
    send(1, 64'h0123_4567_89AB_CDEF, 3'd2, 2'd2, 1'b0, 64'd0, 1'b1);
    send(1, 64'h0123_4567_89AB_CDEF, 3'd1, 2'd1, 1'b0, 64'd0, 1'b1);
    chk("err_cnt64_3", {62'd0, ec64}, 64'd3);
    send(1, 64'h0123_4567_89AB_CDEF, 3'd1, 2'd3, 1'b0, 64'd0, 1'b1);
    chk("err_cnt64_sat", {62'd0, ec64}, 64'd3);

    // Backpressure: A,B fill the buffer, C must wait
    out_ready = 1'b0;
    send(0, 64'h11223344, 3'd0, 2'd2, 1'b0, 64'h11223344, 1'b0);
    send(0, 64'hAABBCCDD, 3'd1, 2'd0, 1'b1, 64'h000000CC, 1'b0);
    fork
      begin
        send(0, 64'hAABBCCDD, 3'd2, 2'd1, 1'b0, 64'hFFFFAABB, 1'b0);
        c_done = 1'b1;
      end
    join_none
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", {63'd0, ir32}, 64'd0);
      chk("stall_out_data", {32'd0, od32}, 64'h11223344);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int t = 0; t < 50 && !c_done; t++) @(posedge clk);
    chk("c_accepted", {63'd0, c_done}, 64'd1);
    for (int t = 0; t < 50 && (q32.size() != 0 || q64.size() != 0); t++) @(posedge clk);
    chk("drain_q32", 64'(q32.size()), 64'd0);
    chk("drain_q64", 64'(q64.size()), 64'd0);
    @(posedge clk); #1;

    // Reset while FULL discards everything
    out_ready = 1'b0;
    send(0, 64'h000000FF, 3'd0, 2'd0, 1'b1, 64'h000000FF, 1'b0);
    send(0, 64'h000000FF, 3'd1, 2'd1, 1'b1, 64'd0, 1'b1);
    chk("pre_rst_full", {63'd0, ir32}, 64'd0);
    rst = 1'b1;
    #1;
    q32.delete();
    chk("mid_rst_out_valid", {63'd0, ov32}, 64'd0);
    chk("mid_rst_err_cnt", {48'd0, ec32}, 64'd0);
    chk("mid_rst_err_cnt64", {62'd0, ec64}, 64'd0);
    chk("mid_rst_out_data", {32'd0, od32}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(0, 64'hCAFEF00D, 3'd2, 2'd1, 1'b0, 64'hFFFFCAFE, 1'b0);
    chk("post_rst_latency", {63'd0, ov32}, 64'd1);
    for (int t = 0; t < 20 && q32.size() != 0; t++) @(posedge clk);
    chk("post_rst_drain", 64'(q32.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
